fb_scanout: RTL and testbench

- Read-side counterpart of the metaball pixel writer.
- Scans one complete frame out of the double-buffered frame store: top buffer (words 0–1023), then bottom buffer (words 1024–2047).
- Presents the frame as a valid/ready pixel stream with start-of-frame, end-of-line and end-of-frame tags, for the display driver.
- Absorbs the 1-cycle synchronous-RAM read latency and downstream backpressure in a 2-entry output FIFO.

---
 rtl/fb_scanout.sv | 203 ++++++++++++++++++++
 tb/tb_fb_scanout.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// fb_scanout -- frame-store scan-out engine.
//
// Reads one full frame from the double-buffered frame store, top buffer
// (words 0..1023) first and then the bottom buffer (words 1024..2047).
// It presents the frame as a valid/ready pixel stream for the display driver.
// A 2-entry output FIFO absorbs the one-cycle RAM read latency and any
// downstream backpressure. Issue is credit-limited, so the FIFO can never
// overflow.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          asynchronous active-low reset
//   frame_start  one-cycle pulse, begin scanning a frame
//   rd_en        buffer read enable
//   rd_sel       buffer select (0 = top, 1 = bottom)
//   rd_addr      buffer word address
//   rd_data      buffer read data, valid the cycle after rd_en
//   pix_valid    stream word available
//   pix_ready    downstream accepts word
//   pix_data     pixel value
//   pix_sof      tag: first word of frame
//   pix_eol      tag: last word of a display line
//   pix_eof      tag: last word of frame
//   busy         frame in progress
//   frame_done   one-cycle pulse after the last word is accepted
//   overrun      one-cycle pulse, frame_start arrived while busy
//
// State | meaning
// IDLE  | waiting for frame_start
// READ  | issuing buffer reads as credit allows
// DRAIN | all reads issued, waiting for the eof word to be accepted

module fb_scanout #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 12,
    parameter int LINE_LEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    output logic              rd_en,
    output logic              rd_sel,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int IDX_W   = ADDR_W + 1;
    localparam int LINE_W  = $clog2(LINE_LEN);
    localparam int ENTRY_W = DATA_W + 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;

    // Read stage: the tags travel alongside the outstanding RAM read.
    logic               inflight;
    logic [2:0]         inflight_tag;   // {sof, eol, eof}

    // FIFO entries are {sof, eol, eof, data}; head drives the stream outputs.
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] tail;
    logic [1:0]         count;

    logic               pop;
    logic               push;
    logic [ENTRY_W-1:0] push_word;
    logic [2:0]         held;
    logic [2:0]         limit;
    logic               start_ok;
    logic               issue_sof;
    logic               issue_eol;
    logic               issue_eof;

    assign pix_valid = (count != 2'd0);
    assign pop       = pix_valid && pix_ready;
    assign push      = inflight;
    assign push_word = {inflight_tag, rd_data};

    // A word leaving this cycle frees its slot in time for a new issue.
    // The held + in-flight total therefore never exceeds two, and full
    // throughput is kept under continuous ready.
    assign held  = {1'b0, count} + {2'b00, inflight};
    assign limit = 3'd2 + {2'b00, pop};
    assign rd_en = (state == READ) && (held < limit);

    assign rd_sel  = idx[IDX_W-1];
    assign rd_addr = idx[ADDR_W-1:0];

    assign issue_sof = (idx == '0);
    assign issue_eol = (idx[LINE_W-1:0] == LINE_W'(LINE_LEN - 1));
    assign issue_eof = (&idx);

    assign busy = (state != IDLE);

    // The frame_done cycle still counts as part of the finishing frame.
    // A start request there is refused like any other mid-frame request.
    assign start_ok = (state == IDLE) && !frame_done;

    assign pix_data = head[DATA_W-1:0];
    assign pix_sof  = head[DATA_W+2];
    assign pix_eol  = head[DATA_W+1];
    assign pix_eof  = head[DATA_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= frame_start && !start_ok;
            case (state)
                IDLE: begin
                    if (frame_start && start_ok) begin
                        state <= READ;
                        idx   <= '0;
                    end
                end
                READ: begin
                    if (rd_en) begin
                        idx <= idx + 1'b1;
                        if (issue_eof) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && pix_eof) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight     <= 1'b0;
            inflight_tag <= 3'b000;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                inflight_tag <= {issue_sof, issue_eol, issue_eof};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= push_word;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= push_word;
                    end else if (push) begin
                        tail  <= push_word;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head <= tail;
                        if (push) begin
                            tail <= push_word;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Testbench for fb_scanout: table-driven start-up vectors plus directed
// multi-frame sequences (backpressure, overrun, mid-frame reset, buffer
// boundary) checked against a bench-side expectation of word k = k.
// A second instance built with LINE_LEN=4 checks the eol spacing.

module tb_fb_scanout;

    localparam int LINE_LEN = 32;
    localparam int FRAME    = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        pix_ready;

    logic        rd_en, rd_sel;
    logic [9:0]  rd_addr;
    logic [11:0] rd_data, pix_data;
    logic        pix_valid, pix_sof, pix_eol, pix_eof, busy, frame_done, overrun;

    logic        rd_en_4, rd_sel_4;
    logic [9:0]  rd_addr_4;
    logic [11:0] rd_data_4, pix_data_4;
    logic        pix_valid_4, pix_sof_4, pix_eol_4, pix_eof_4, busy_4, frame_done_4, overrun_4;

    always #5 clk = ~clk;

    fb_scanout #(.ADDR_W(10), .DATA_W(12), .LINE_LEN(LINE_LEN)) u_dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    fb_scanout #(.ADDR_W(10), .DATA_W(12), .LINE_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .rd_en(rd_en_4), .rd_sel(rd_sel_4), .rd_addr(rd_addr_4), .rd_data(rd_data_4),
        .pix_valid(pix_valid_4), .pix_ready(pix_ready), .pix_data(pix_data_4),
        .pix_sof(pix_sof_4), .pix_eol(pix_eol_4), .pix_eof(pix_eof_4),
        .busy(busy_4), .frame_done(frame_done_4), .overrun(overrun_4)
    );

    // Synchronous RAM models: word k holds k; idle cycles return a marker value.
    always @(posedge clk) begin
        rd_data   <= rd_en   ? 12'({rd_sel, rd_addr})     : 12'hFFF;
        rd_data_4 <= rd_en_4 ? 12'({rd_sel_4, rd_addr_4}) : 12'hFFF;
    end

    typedef struct packed {
        logic [11:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } word_t;

    word_t       words[$];
    logic [10:0] issues[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0, n_iss = 0, n_acc = 0, n_done = 0, n_ovr = 0;
    int fs_cyc = 0, done_cyc = 0, eof_cyc = 0;
    int stall_err = 0, max_out = 0, e4 = 0, eol4 = 0;
    logic        stall_q = 1'b0;
    logic [14:0] held_q  = '0;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            cyc++;
            if (frame_start) fs_cyc = cyc;
            if (stall_q) begin
                if (!pix_valid || {pix_data, pix_sof, pix_eol, pix_eof} != held_q) stall_err++;
            end
            stall_q = pix_valid && !pix_ready;
            held_q  = {pix_data, pix_sof, pix_eol, pix_eof};
            if (pix_valid && pix_ready) begin
                words.push_back({pix_data, pix_sof, pix_eol, pix_eof});
                n_acc++;
                if (pix_eof) eof_cyc = cyc;
            end
            if (rd_en) begin
                issues.push_back({rd_sel, rd_addr});
                n_iss++;
            end
            if (n_iss - n_acc > max_out) max_out = n_iss - n_acc;
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (overrun) n_ovr++;
            if (pix_valid_4 && pix_ready) begin
                if (pix_eol_4 != (pix_data_4[1:0] == 2'b11)) e4++;
                if (pix_eol_4) eol4++;
            end
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic [30:0] all_outs();
        return {rd_en, rd_sel, rd_addr, pix_valid, pix_data, pix_sof, pix_eol,
                pix_eof, busy, frame_done, overrun};
    endfunction

    task automatic clear_stats();
        words.delete();
        issues.delete();
        n_iss = 0; n_acc = 0; n_done = 0; n_ovr = 0;
        stall_err = 0; max_out = 0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        clear_stats();
        frame_start = 1'b1;
        pix_ready   = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic run_until_done(input int mode, input string tag);
        int  start = n_done;
        logic got = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (n_done != start) begin
                got = 1'b1;
                break;
            end
            pix_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(got), 1);
        pix_ready = 1'b1;
    endtask

    task automatic wait_acc(input int target, input string tag);
        logic got = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (n_acc >= target) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            pix_ready = 1'b1;
        end
        chk({tag, "_reached"}, 32'(got), 1);
    endtask

    task automatic check_frame(input string tag);
        int bad = 0;
        chk({tag, "_len"}, words.size(), FRAME);
        for (int k = 0; k < words.size() && k < FRAME; k++) begin
            if (words[k].data != 12'(k) || words[k].sof != (k == 0) ||
                words[k].eol != ((k % LINE_LEN) == LINE_LEN - 1) ||
                words[k].eof != (k == FRAME - 1)) bad++;
        end
        chk({tag, "_word_errors"}, bad, 0);
    endtask

    typedef struct {
        logic        fs;
        logic        rdy;
        logic        en;
        logic [9:0]  addr;
        logic        v;
        logic [11:0] d;
        logic        sof;
        logic        bsy;
    } vec_t;

    function automatic vec_t mk(int fs, int rdy, int en, int addr, int v, int d, int sof, int bsy);
        vec_t m;
        m.fs = 1'(fs); m.rdy = 1'(rdy); m.en = 1'(en); m.addr = 10'(addr);
        m.v = 1'(v); m.d = 12'(d); m.sof = 1'(sof); m.bsy = 1'(bsy);
        return m;
    endfunction

    vec_t vt[10];

    initial begin
        //           fs rdy en addr v  d  sof busy
        vt[0] = mk(1, 1, 0, 0, 0, 0, 0, 0);
        vt[1] = mk(0, 1, 1, 0, 0, 0, 0, 1);
        vt[2] = mk(0, 1, 1, 1, 0, 0, 0, 1);
        vt[3] = mk(0, 1, 1, 2, 1, 0, 1, 1);
        vt[4] = mk(0, 1, 1, 3, 1, 1, 0, 1);
        vt[5] = mk(0, 0, 0, 4, 1, 2, 0, 1);
        vt[6] = mk(0, 0, 0, 4, 1, 2, 0, 1);
        vt[7] = mk(0, 1, 1, 4, 1, 2, 0, 1);
        vt[8] = mk(0, 1, 1, 5, 1, 3, 0, 1);
        vt[9] = mk(0, 1, 1, 6, 1, 4, 0, 1);

        rst = 1'b0;
        frame_start = 1'b0;
        pix_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(all_outs()), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Frame 1: start-up vectors including a two-cycle stall, then run out.
        clear_stats();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            frame_start = vt[i].fs;
            pix_ready   = vt[i].rdy;
            #1;
            chk($sformatf("vec%0d_rd_en", i), 32'(rd_en), 32'(vt[i].en));
            chk($sformatf("vec%0d_rd_addr", i), 32'(rd_addr), 32'(vt[i].addr));
            chk($sformatf("vec%0d_pix_valid", i), 32'(pix_valid), 32'(vt[i].v));
            chk($sformatf("vec%0d_pix_data", i), 32'(pix_data), 32'(vt[i].d));
            chk($sformatf("vec%0d_pix_sof", i), 32'(pix_sof), 32'(vt[i].sof));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].bsy));
        end
        run_until_done(0, "f1");
        check_frame("f1");
        chk("f1_done_after_eof", done_cyc - eof_cyc, 1);
        chk("f1_busy_after", 32'(busy), 0);
        repeat (5) @(negedge clk);
        chk("f1_done_pulses", n_done, 1);
        chk("f1_stall_errors", stall_err, 0);

        // Frame 2: clean run, frame length and buffer boundary trace.
        start_frame();
        run_until_done(0, "f2");
        check_frame("f2");
        chk("f2_cycles", done_cyc - fs_cyc, 2051);
        chk("f2_issues", issues.size(), FRAME);
        if (issues.size() >= 1026) begin
            chk("f2_issue_1022", 32'(issues[1022]), 32'({1'b0, 10'd1022}));
            chk("f2_issue_1023", 32'(issues[1023]), 32'({1'b0, 10'd1023}));
            chk("f2_issue_1024", 32'(issues[1024]), 32'({1'b1, 10'd0}));
            chk("f2_issue_1025", 32'(issues[1025]), 32'({1'b1, 10'd1}));
        end

        // Frame 3: random backpressure.
        start_frame();
        run_until_done(1, "f3");
        check_frame("f3");
        chk("f3_outstanding_le2", 32'(max_out <= 2), 1);
        chk("f3_stall_errors", stall_err, 0);

        // Frame 4: ready held low for 100 cycles at word 500.
        start_frame();
        wait_acc(500, "f4_word500");
        pix_ready = 1'b0;
        repeat (100) @(negedge clk);
        chk("f4_issued_during_stall_le502", 32'(n_iss <= 502), 1);
        chk("f4_accepted_during_stall", n_acc, 500);
        chk("f4_valid_during_stall", 32'(pix_valid), 1);
        pix_ready = 1'b1;
        run_until_done(0, "f4");
        check_frame("f4");
        chk("f4_stall_errors", stall_err, 0);

        // Frame 5: start requests at word 1000 and on the frame_done cycle.
        start_frame();
        wait_acc(1000, "f5_word1000");
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        begin
            logic got = 1'b0;
            for (int c = 0; c < 5000; c++) begin
                @(negedge clk);
                if (frame_done) begin
                    frame_start = 1'b1;
                    @(negedge clk);
                    frame_start = 1'b0;
                    got = 1'b1;
                    break;
                end
            end
            chk("f5_done_seen", 32'(got), 1);
        end
        repeat (30) @(negedge clk);
        chk("f5_overruns", n_ovr, 2);
        check_frame("f5");
        chk("f5_no_restart_issues", n_iss, FRAME);
        chk("f5_busy_after", 32'(busy), 0);
        chk("f5_done_pulses", n_done, 1);

        // Frame 6: asynchronous reset at word 1500, then a full fresh frame.
        start_frame();
        wait_acc(1500, "f6_word1500");
        #2 rst = 1'b0;
        #1 chk("f6_reset_outputs", 32'(all_outs()), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_frame();
        run_until_done(0, "f7");
        check_frame("f7");

        chk("dut4_eol_errors", e4, 0);
        chk("dut4_eol_seen", 32'(eol4 >= 512), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
